// File: rtl/pic_motion_ctrl_pkg.sv
// Shared types and derivations for the bouncing picture-window controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package pic_motion_ctrl_pkg;

   // Frame-update sequencer states
   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      CALC    = 2'd1,
      COMMIT  = 2'd2
   } motion_state_t;

   // Direction flag encoding used by every axis
   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   // Largest legal window origin along one axis (window flush with far edge)
   function automatic int travel_max(input int act, input int pic);
      return act - pic;
   endfunction

   // Window origin that centres the picture along one axis
   function automatic int center_pos(input int act, input int pic);
      return (act - pic) / 2;
   endfunction

endpackage

// File: rtl/pic_motion_ctrl_bounce_axis.sv
// One axis of the bouncing window: next origin and direction from current state and step.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the result.
// Ports: pos/dir = current origin and direction, step = magnitude (0 holds),
//        pos_nxt/dir_nxt = origin and direction after one update.
module bounce_axis
   import pic_motion_ctrl_pkg::*;
#(
   parameter int W   = 12,
   parameter int MAX = 1024
) (
   input  logic [W-1:0] pos,
   input  logic         dir,
   input  logic [3:0]   step,
   output logic [W-1:0] pos_nxt,
   output logic         dir_nxt
);

   localparam logic [W:0]   MAX_E = (W+1)'(MAX);
   localparam logic [W-1:0] MAX_P = W'(MAX);

   // One guard bit so pos+step near the top of the range cannot wrap
   logic [W:0] pos_e;
   logic [W:0] step_e;
   logic [W:0] sum;

   assign pos_e  = {1'b0, pos};
   assign step_e = (W+1)'(step);
   assign sum    = pos_e + step_e;

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir;
      // A zero step leaves the axis frozen, including its direction
      if (step != 4'd0) begin
         if (dir == DIR_INC) begin
            if (sum >= MAX_E) begin
               pos_nxt = MAX_P;
               dir_nxt = DIR_DEC;
            end else begin
               pos_nxt = sum[W-1:0];
            end
         end else begin
            if (pos_e <= step_e) begin
               pos_nxt = '0;
               dir_nxt = DIR_INC;
            end else begin
               pos_nxt = pos - W'(step);
            end
         end
      end
   end

endmodule

// File: rtl/pic_motion_ctrl.sv
// Frame-synchronous bouncing position controller and picture-ROM address sequencer.
// Latency: window update commits 2 cycles after vs rise; pic_vld trails the hit by 1 cycle.
// Backpressure: none; follows the free-running timing generator.
// Ports: pix_clk/rstn clock and async active-low reset; act_x/act_y/vs_in/de_in from timing gen;
//        run/step_req/dx_cfg/dy_cfg motion control; pos_x/pos_y committed window origin;
//        rom_addr/pic_vld ROM address and aligned data-valid; frame_tick pulses on each commit.
module pic_motion_ctrl
   import pic_motion_ctrl_pkg::*;
#(
   parameter int X_BITS    = 12,
   parameter int Y_BITS    = 12,
   parameter int H_ACT     = 1280,
   parameter int V_ACT     = 720,
   parameter int PIC_W     = 256,
   parameter int PIC_H     = 256,
   parameter int ADDR_BITS = 16
) (
   input  logic                 pix_clk,
   input  logic                 rstn,
   input  logic [X_BITS-1:0]    act_x,
   input  logic [Y_BITS-1:0]    act_y,
   input  logic                 vs_in,
   input  logic                 de_in,
   input  logic                 run,
   input  logic                 step_req,
   input  logic [3:0]           dx_cfg,
   input  logic [3:0]           dy_cfg,
   output logic [X_BITS-1:0]    pos_x,
   output logic [Y_BITS-1:0]    pos_y,
   output logic [ADDR_BITS-1:0] rom_addr,
   output logic                 pic_vld,
   output logic                 frame_tick
);

   localparam int MAX_X = travel_max(H_ACT, PIC_W);
   localparam int MAX_Y = travel_max(V_ACT, PIC_H);
   localparam logic [X_BITS-1:0] CTR_X   = X_BITS'(center_pos(H_ACT, PIC_W));
   localparam logic [Y_BITS-1:0] CTR_Y   = Y_BITS'(center_pos(V_ACT, PIC_H));
   localparam logic [X_BITS:0]   PIC_W_E = (X_BITS+1)'(PIC_W);
   localparam logic [Y_BITS:0]   PIC_H_E = (Y_BITS+1)'(PIC_H);

   motion_state_t state;
   motion_state_t state_nxt;

   logic vs_d;
   logic vs_rise;
   logic step_pend;
   logic calc_en;
   logic commit_en;

   logic              dir_x;
   logic              dir_y;
   logic [X_BITS-1:0] x_nxt;
   logic [Y_BITS-1:0] y_nxt;
   logic              xdir_nxt;
   logic              ydir_nxt;
   logic [X_BITS-1:0] x_calc;
   logic [Y_BITS-1:0] y_calc;
   logic              xdir_calc;
   logic              ydir_calc;

   logic hit_x;
   logic hit_y;
   logic hit;

   assign vs_rise = vs_in & ~vs_d;

   bounce_axis #(.W(X_BITS), .MAX(MAX_X)) u_axis_x (
      .pos     (pos_x),
      .dir     (dir_x),
      .step    (dx_cfg),
      .pos_nxt (x_nxt),
      .dir_nxt (xdir_nxt)
   );

   bounce_axis #(.W(Y_BITS), .MAX(MAX_Y)) u_axis_y (
      .pos     (pos_y),
      .dir     (dir_y),
      .step    (dy_cfg),
      .pos_nxt (y_nxt),
      .dir_nxt (ydir_nxt)
   );

   // ---------------- update sequencer ----------------
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) state <= WAIT_VS;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      calc_en    = 1'b0;
      commit_en  = 1'b0;
      frame_tick = 1'b0;
      case (state)
         // step_req is tested directly so a request landing on the edge itself counts
         WAIT_VS: if (vs_rise && (run || step_pend || step_req)) state_nxt = CALC;
         CALC: begin
            calc_en   = 1'b1;
            state_nxt = COMMIT;
         end
         COMMIT: begin
            commit_en  = 1'b1;
            frame_tick = 1'b1;
            state_nxt  = WAIT_VS;
         end
         default: state_nxt = WAIT_VS;
      endcase
   end

   // ---------------- motion state ----------------
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         vs_d      <= 1'b0;
         step_pend <= 1'b0;
         pos_x     <= CTR_X;
         pos_y     <= CTR_Y;
         dir_x     <= DIR_INC;
         dir_y     <= DIR_INC;
         x_calc    <= CTR_X;
         y_calc    <= CTR_Y;
         xdir_calc <= DIR_INC;
         ydir_calc <= DIR_INC;
      end else begin
         vs_d <= vs_in;

         // Pending single step collapses any number of requests into one update
         if (run)            step_pend <= 1'b0;
         else if (step_req)  step_pend <= 1'b1;
         else if (commit_en) step_pend <= 1'b0;

         // Config is sampled here only, so mid-frame changes wait for the next update
         if (calc_en) begin
            x_calc    <= x_nxt;
            y_calc    <= y_nxt;
            xdir_calc <= xdir_nxt;
            ydir_calc <= ydir_nxt;
         end

         if (commit_en) begin
            pos_x <= x_calc;
            pos_y <= y_calc;
            dir_x <= xdir_calc;
            dir_y <= ydir_calc;
         end
      end
   end

   // ---------------- window hit and ROM addressing ----------------
   assign hit_x = ({1'b0, act_x} >= {1'b0, pos_x}) &&
                  ({1'b0, act_x} <  ({1'b0, pos_x} + PIC_W_E));
   assign hit_y = ({1'b0, act_y} >= {1'b0, pos_y}) &&
                  ({1'b0, act_y} <  ({1'b0, pos_y} + PIC_H_E));
   assign hit   = de_in & hit_x & hit_y;

   // rom_addr holds the index of the pixel being hit; raster order makes a counter enough
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         rom_addr <= '0;
         pic_vld  <= 1'b0;
      end else begin
         if (vs_rise)  rom_addr <= '0;
         else if (hit) rom_addr <= rom_addr + ADDR_BITS'(1);
         // ROM returns data one cycle after the address, so valid trails the hit by one
         pic_vld <= hit;
      end
   end

endmodule

// File: tb/tb_pic_motion_ctrl.sv
module tb_pic_motion_ctrl;

   logic        pix_clk;
   logic        rstn;
   logic [11:0] act_x;
   logic [11:0] act_y;
   logic        vs_in;
   logic        de_in;
   logic        run;
   logic        step_req;
   logic [3:0]  dx_cfg;
   logic [3:0]  dy_cfg;
   logic [11:0] pos_x;
   logic [11:0] pos_y;
   logic [15:0] rom_addr;
   logic        pic_vld;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;
   int ticks = 0;
   int vlds  = 0;

   pic_motion_ctrl dut (
      .pix_clk    (pix_clk),
      .rstn       (rstn),
      .act_x      (act_x),
      .act_y      (act_y),
      .vs_in      (vs_in),
      .de_in      (de_in),
      .run        (run),
      .step_req   (step_req),
      .dx_cfg     (dx_cfg),
      .dy_cfg     (dy_cfg),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .rom_addr   (rom_addr),
      .pic_vld    (pic_vld),
      .frame_tick (frame_tick)
   );

   initial pix_clk = 1'b0;
   always #5 pix_clk = ~pix_clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic summary();
      $display("test done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
         if (bad >= 200) begin
            summary();
            $finish;
         end
      end
   endtask

   // ---------------- reference model ----------------
   // Positions as signed integers, direction as +1/-1; a step is pos+dir*d clamped at the ends.
   int m_px, m_py, m_dx, m_dy;
   int m_nx, m_ny, m_ndx, m_ndy;
   int m_age;        // -1 idle, 0 = cycle after triggering edge, 1 = commit cycle
   int m_addr;
   bit m_pend, m_vs_prev, m_vld;

   task automatic bounce(inout int p, inout int dir, input int d, input int mx);
      int t;
      if (d != 0) begin
         t = p + dir * d;
         if (t >= mx)     begin p = mx; dir = -1; end
         else if (t <= 0) begin p = 0;  dir = 1;  end
         else             p = t;
      end
   endtask

   always @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         m_px = 512; m_py = 232; m_dx = 1; m_dy = 1;
         m_nx = 512; m_ny = 232; m_ndx = 1; m_ndy = 1;
         m_age = -1; m_addr = 0; m_pend = 0; m_vs_prev = 0; m_vld = 0;
      end else begin : model_step
         bit hit, rise, commit;
         hit = de_in && (int'(act_x) >= m_px) && (int'(act_x) < m_px + 256) &&
               (int'(act_y) >= m_py) && (int'(act_y) < m_py + 256);
         rise = vs_in && !m_vs_prev;
         commit = 0;
         if (m_age == 1) begin
            m_px = m_nx; m_py = m_ny; m_dx = m_ndx; m_dy = m_ndy;
            m_age = -1; commit = 1;
         end else if (m_age == 0) begin
            m_nx = m_px; m_ndx = m_dx; bounce(m_nx, m_ndx, int'(dx_cfg), 1024);
            m_ny = m_py; m_ndy = m_dy; bounce(m_ny, m_ndy, int'(dy_cfg), 464);
            m_age = 1;
         end else if (rise && (run || m_pend || step_req)) begin
            m_age = 0;
         end
         if (run)           m_pend = 0;
         else if (step_req) m_pend = 1;
         else if (commit)   m_pend = 0;
         if (rise)     m_addr = 0;
         else if (hit) m_addr = (m_addr + 1) % 65536;
         m_vld = hit;
         m_vs_prev = vs_in;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n = 1);
      repeat (n) @(posedge pix_clk);
      #1;
   endtask

   task automatic vs_frame(input int gap);
      vs_in = 1'b1;
      cyc(3);
      vs_in = 1'b0;
      cyc(gap);
   endtask

   initial begin
      int t0, tx, ty;
      rstn = 1'b0; vs_in = 1'b0; de_in = 1'b0; run = 1'b0; step_req = 1'b0;
      act_x = '0; act_y = '0; dx_cfg = '0; dy_cfg = '0;

      fork
         forever begin
            @(negedge pix_clk);
            chk("pos_x", pos_x, m_px);
            chk("pos_y", pos_y, m_py);
            chk("rom_addr", rom_addr, m_addr);
            chk("pic_vld", pic_vld, m_vld);
            chk("frame_tick", frame_tick, int'(m_age == 1));
            if (frame_tick) ticks++;
            if (pic_vld) vlds++;
         end
      join_none

      // 1. reset, no vsync
      cyc(3);
      rstn = 1'b1;
      t0 = ticks;
      cyc(20);
      chk("rst_pos_x", pos_x, 512);
      chk("rst_pos_y", pos_y, 232);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_pic_vld", pic_vld, 0);
      chk("rst_no_tick", ticks - t0, 0);

      // 2. free run, x only
      run = 1'b1; dx_cfg = 4'd4; dy_cfg = 4'd0;
      t0 = ticks;
      repeat (10) vs_frame(8);
      chk("run_ticks", ticks - t0, 10);
      chk("run_pos_x", pos_x, 552);
      chk("run_pos_y", pos_y, 232);
      chk("model_run_pos_x", m_px, 552);

      // 3. right-edge and left-edge bounce
      repeat (117) vs_frame(6);
      chk("pre_right_x", pos_x, 1020);
      dx_cfg = 4'd8;
      vs_frame(6);
      chk("right_clamp_x", pos_x, 1024);
      vs_frame(6);
      chk("right_back_x", pos_x, 1016);
      repeat (126) vs_frame(6);
      chk("pre_left_x8", pos_x, 8);
      dx_cfg = 4'd5;
      vs_frame(6);
      chk("pre_left_x3", pos_x, 3);
      dx_cfg = 4'd4;
      vs_frame(6);
      chk("left_clamp_x", pos_x, 0);
      vs_frame(6);
      chk("left_back_x", pos_x, 4);
      chk("bounce_pos_y", pos_y, 232);
      chk("model_left_back_x", m_px, 4);

      // 4. single-step mode
      run = 1'b0; dx_cfg = 4'd2; dy_cfg = 4'd3;
      cyc(2);
      t0 = ticks;
      repeat (3) begin
         step_req = 1'b1; cyc(1); step_req = 1'b0; cyc(3);
      end
      vs_frame(8);
      chk("step_ticks", ticks - t0, 1);
      chk("step_pos_x", pos_x, 6);
      chk("step_pos_y", pos_y, 235);
      t0 = ticks;
      repeat (3) vs_frame(8);
      chk("idle_ticks", ticks - t0, 0);
      chk("idle_pos_x", pos_x, 6);
      vs_in = 1'b1; step_req = 1'b1;
      cyc(1);
      step_req = 1'b0;
      cyc(2);
      vs_in = 1'b0;
      cyc(8);
      chk("edge_step_x", pos_x, 8);
      chk("edge_step_y", pos_y, 238);
      t0 = ticks;
      step_req = 1'b1; cyc(1); step_req = 1'b0;
      run = 1'b1; cyc(1); run = 1'b0; cyc(2);
      vs_frame(8);
      chk("run_clears_pend", ticks - t0, 0);
      chk("run_clears_pos_x", pos_x, 8);

      // 5. full window scan around (8,238)
      vs_frame(4);
      t0 = vlds;
      for (int y = 237; y <= 494; y++) begin
         for (int x = 7; x <= 264; x++) begin
            act_x = 12'(x); act_y = 12'(y); de_in = 1'b1;
            #1;
            if (x >= 8 && x < 264 && y >= 238 && y < 494)
               chk("scan_addr", rom_addr, (y - 238) * 256 + (x - 8));
            @(posedge pix_clk); #1;
         end
      end
      de_in = 1'b0;
      cyc(3);
      chk("scan_vld_count", vlds - t0, 65536);
      chk("scan_wrap_addr", rom_addr, 0);
      act_x = 12'd8; act_y = 12'd238; de_in = 1'b1;
      cyc(5);
      chk("pre_vs_addr", rom_addr, 5);
      vs_in = 1'b1;
      cyc(1);
      chk("vs_overrides_hit", rom_addr, 0);
      de_in = 1'b0;
      cyc(2);
      vs_in = 1'b0;
      cyc(4);

      // 6. reset in the middle of hits
      vs_frame(6);
      for (int x = 0; x < 100; x++) begin
         act_x = 12'(x); act_y = 12'd238; de_in = 1'b1;
         cyc(1);
      end
      chk("pre_reset_addr", rom_addr, 92);
      act_x = 12'd100;
      rstn = 1'b0;
      #1;
      chk("midrst_pos_x", pos_x, 512);
      chk("midrst_pos_y", pos_y, 232);
      chk("midrst_addr", rom_addr, 0);
      chk("midrst_vld", pic_vld, 0);
      chk("midrst_tick", frame_tick, 0);
      de_in = 1'b0;
      cyc(2);
      rstn = 1'b1;
      cyc(2);
      vs_frame(6);
      for (int y = 232; y <= 233; y++) begin
         for (int x = 505; x <= 775; x++) begin
            act_x = 12'(x); act_y = 12'(y); de_in = 1'b1;
            #1;
            if (x >= 512 && x < 768)
               chk("post_rst_addr", rom_addr, (y - 232) * 256 + (x - 512));
            @(posedge pix_clk); #1;
         end
      end
      de_in = 1'b0;
      cyc(2);

      // 7. randomized frames against the model
      for (int f = 0; f < 120; f++) begin
         run = ($urandom_range(0, 1) == 0);
         dx_cfg = 4'($urandom_range(0, 15));
         dy_cfg = 4'($urandom_range(0, 15));
         vs_in = 1'b1; cyc(2); vs_in = 1'b0; step_req = 1'b0; cyc(4);
         for (int c = 0; c < 30; c++) begin
            step_req = ($urandom_range(0, 9) == 0);
            de_in = ($urandom_range(0, 3) != 0);
            tx = m_px - 3 + int'($urandom_range(0, 262));
            ty = m_py - 2 + int'($urandom_range(0, 259));
            if (tx < 0) tx = 0;
            if (ty < 0) ty = 0;
            act_x = 12'(tx); act_y = 12'(ty);
            if ($urandom_range(0, 15) == 0) dx_cfg = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) dy_cfg = 4'($urandom_range(0, 15));
            rstn = !(f == 60 && c == 15);
            cyc(1);
         end
         step_req = 1'b0; de_in = 1'b0; rstn = 1'b1;
         cyc(2);
      end

      cyc(4);
      summary();
      $finish;
   end

endmodule
